// File: rtl/aes128_sub_bytes_par.sv
// aes128_sub_bytes_par: buffers an AES state and streams it out LANES bytes per beat through (Inv)SubBytes
module aes128_sub_bytes_par #(
    parameter int N_BYTES       = 16,
    parameter int LANES         = 4,
    parameter int INVERSE_EN    = 1,
    parameter int EXTERNAL_SBOX = 0,
    localparam int AW           = (N_BYTES > 1) ? $clog2(N_BYTES) : 1,
    localparam int DW           = LANES * 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic [N_BYTES*8-1:0] data_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [DW-1:0]        data_o,
    output logic [AW-1:0]        addr_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DW-1:0]        sbox_sub_o,
    output logic                 sbox_inv_o,
    input  logic [DW-1:0]        sbox_sub_i
);
    localparam int N_BEATS = N_BYTES / LANES;
    localparam int BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int LS      = $clog2(DW);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16) || N_BYTES % LANES != 0) begin : g_bad_lanes
        $error("LANES must be 1, 2, 4, 8 or 16 and divide N_BYTES");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [N_BYTES*8-1:0] job_q;
    logic                 mode_q;
    logic [BW-1:0]        beat_q;
    logic                 run, at_last, fire, take;
    logic [DW-1:0]        cur, sub;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p, r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    assign run     = state_q == RUN;
    assign at_last = beat_q == BW'(N_BEATS - 1);
    assign fire    = run && ready_i;
    assign take    = !run && start_i;
    assign cur     = DW'(job_q >> {beat_q, LS'(0)});

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next state: start only from IDLE, back to IDLE once the final beat is taken
    always_comb begin
        state_d = take ? RUN : (fire && at_last) ? IDLE : state_q;
    end

    // job buffer, latched mode and beat counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            job_q  <= '0;
            mode_q <= 1'b0;
            beat_q <= '0;
        end else if (take) begin
            job_q  <= data_i;
            mode_q <= (INVERSE_EN != 0) && mode_i;
            beat_q <= '0;
        end else if (fire) begin
            beat_q <= at_last ? '0 : beat_q + 1'b1;
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign sub[8*j +: 8] = (EXTERNAL_SBOX != 0) ? sbox_sub_i[8*j +: 8] :
                               mode_q ? inv_sbox(cur[8*j +: 8]) : fwd_sbox(cur[8*j +: 8]);
    end

    assign valid_o    = run;
    assign busy_o     = run;
    assign last_o     = run && at_last;
    assign done_o     = fire && at_last;
    assign addr_o     = run ? AW'(int'(beat_q) * LANES) : '0;
    assign data_o     = run ? sub : '0;
    assign sbox_sub_o = (EXTERNAL_SBOX != 0 && run) ? cur : '0;
    assign sbox_inv_o = (EXTERNAL_SBOX != 0) && run && mode_q;
endmodule

// File: tb/tb_aes128_sub_bytes_par.sv
// tb_aes128_sub_bytes_par: random and directed jobs checked against a FIPS-197 table model
module tb_aes128_sub_bytes_par;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic         rst_i, start_i, mode_i, ready_i;
    logic [127:0] data_i;
    logic         valid_o, last_o, busy_o, done_o, sbox_inv_o;
    logic [31:0]  data_o, sbox_sub_o, sbox_sub_i;
    logic [3:0]   addr_o;

    logic         x_start, x_mode, x_ready;
    logic [127:0] x_data, x_sub_i, x_data_o, x_sbox_sub_o;
    logic         x_valid, x_last, x_busy, x_done, x_inv;
    logic [3:0]   x_addr;

    int n_checks = 0;
    int n_fail   = 0;

    aes128_sub_bytes_par dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i), .data_i(data_i),
        .ready_i(ready_i), .valid_o(valid_o), .data_o(data_o), .addr_o(addr_o), .last_o(last_o),
        .busy_o(busy_o), .done_o(done_o), .sbox_sub_o(sbox_sub_o), .sbox_inv_o(sbox_inv_o),
        .sbox_sub_i(sbox_sub_i)
    );

    aes128_sub_bytes_par #(.N_BYTES(16), .LANES(16), .INVERSE_EN(1), .EXTERNAL_SBOX(1)) dut_ext (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(x_start), .mode_i(x_mode), .data_i(x_data),
        .ready_i(x_ready), .valid_o(x_valid), .data_o(x_data_o), .addr_o(x_addr), .last_o(x_last),
        .busy_o(x_busy), .done_o(x_done), .sbox_sub_o(x_sbox_sub_o), .sbox_inv_o(x_inv),
        .sbox_sub_i(x_sub_i)
    );

    logic [7:0] fwd [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] inv [256];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_beat(input logic [127:0] d, input logic m, input int b);
        logic [31:0] r;
        logic [7:0]  x;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            x = 8'(d >> (8 * (4 * b + j)));
            r = r | (32'(m ? inv[x] : fwd[x]) << (8 * j));
        end
        return r;
    endfunction

    task automatic run_job(input logic [127:0] d, input logic m, input int stall_pct, input bit poke,
                           output logic [127:0] res);
        int b, guard;
        start_i = 1'b1;
        data_i  = d;
        mode_i  = m;
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        b       = 0;
        guard   = 0;
        res     = '0;
        while (b < 4 && guard < 100) begin
            ready_i = $urandom_range(99) >= stall_pct;
            if (poke) begin
                start_i = 1'($urandom_range(1));
                data_i  = {$urandom, $urandom, $urandom, $urandom};
                mode_i  = ~m;
            end
            #1;
            check("valid", 128'(valid_o), 128'(1));
            check("busy", 128'(busy_o), 128'(1));
            check("addr", 128'(addr_o), 128'(4 * b));
            check("data", 128'(data_o), 128'(exp_beat(d, m, b)));
            check("last", 128'(last_o), 128'(b == 3));
            check("done", 128'(done_o), 128'(ready_i && b == 3));
            check("sbox_sub_o", 128'(sbox_sub_o), 128'(0));
            if (ready_i) begin
                res = res | (128'(data_o) << (32 * b));
                b++;
            end
            @(posedge clk_i); #1;
            guard++;
        end
        if (b < 4) check("job_timeout", 128'(b), 128'(4));
        start_i = 1'b0;
        ready_i = 1'b0;
        #1;
        check("idle_valid", 128'(valid_o), 128'(0));
        check("idle_busy", 128'(busy_o), 128'(0));
    endtask

    initial begin
        logic [127:0] d, f, r;
        for (int i = 0; i < 256; i++) inv[fwd[i]] = 8'(i);
        rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; ready_i = 1'b0; data_i = '0; sbox_sub_i = '0;
        x_start = 1'b0; x_mode = 1'b0; x_ready = 1'b0; x_data = '0; x_sub_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("rst_valid", 128'(valid_o), 128'(0));
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_last", 128'(last_o), 128'(0));
        check("rst_done", 128'(done_o), 128'(0));
        check("rst_data", 128'(data_o), 128'(0));
        check("rst_addr", 128'(addr_o), 128'(0));
        check("rst_ext_valid", 128'(x_valid), 128'(0));
        check("rst_ext_sub", x_sbox_sub_o, 128'(0));

        run_job('0, 1'b0, 0, 1'b0, r);
        check("all_zero_fwd", r, {16{8'h63}});

        run_job(128'h0000_0000_0000_0000_0000_0000_0000_ed63, 1'b1, 0, 1'b0, r);
        check("inv_byte0", 128'(r[7:0]), 128'(8'h00));
        check("inv_byte1", 128'(r[15:8]), 128'(8'h53));

        for (int blk = 0; blk < 16; blk++) begin
            for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(blk * 16 + k);
            run_job(d, 1'b0, 30, 1'b1, f);
            run_job(f, 1'b1, 30, 1'b1, r);
            check("roundtrip", r, d);
        end

        for (int t = 0; t < 6; t++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            run_job(d, 1'($urandom_range(1)), 50, 1'b1, r);
        end

        d = {$urandom, $urandom, $urandom, $urandom};
        start_i = 1'b1; data_i = d; mode_i = 1'b0; ready_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("beat2_addr", 128'(addr_o), 128'(8));
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        ready_i = 1'b0;
        #1;
        check("midrst_valid", 128'(valid_o), 128'(0));
        check("midrst_busy", 128'(busy_o), 128'(0));
        check("midrst_done", 128'(done_o), 128'(0));
        run_job({16{8'h01}}, 1'b0, 0, 1'b0, r);
        check("after_rst_job", r, {16{8'h7c}});

        rst_i = 1'b1; start_i = 1'b1; data_i = '0;
        @(posedge clk_i); #1;
        rst_i = 1'b0; start_i = 1'b0;
        #1;
        check("rst_over_start", 128'(valid_o), 128'(0));

        x_data = {$urandom, $urandom, $urandom, $urandom};
        x_sub_i = {$urandom, $urandom, $urandom, $urandom};
        x_mode = 1'b1; x_start = 1'b1;
        @(posedge clk_i); #1;
        x_start = 1'b0;
        #1;
        check("ext_valid", 128'(x_valid), 128'(1));
        check("ext_sub_o", x_sbox_sub_o, x_data);
        check("ext_data", x_data_o, x_sub_i);
        check("ext_inv", 128'(x_inv), 128'(1));
        check("ext_last", 128'(x_last), 128'(1));
        check("ext_addr", 128'(x_addr), 128'(0));
        check("ext_done_stall", 128'(x_done), 128'(0));
        x_sub_i = ~x_sub_i;
        x_ready = 1'b1;
        #1;
        check("ext_data_follow", x_data_o, x_sub_i);
        check("ext_done", 128'(x_done), 128'(1));
        @(posedge clk_i); #1;
        x_ready = 1'b0;
        #1;
        check("ext_idle", 128'(x_valid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
